axil_rdata_fifo_slice: RTL and testbench

- Parametrised AXI4-Lite read-data (R) channel buffer between slave-side R producer and master-side R consumer.
- Replaces the single-register pass-through stage with a DEPTH-entry FIFO carrying RDATA/RRESP under full VALID/READY handshaking on both sides.
- Adds occupancy reporting and a saturating error-response counter (SLVERR/DECERR) for debug.

---
 rtl/axil_rdata_fifo_slice.sv | 109 ++++++++++
 tb/tb_axil_rdata_fifo_slice.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/axil_rdata_fifo_slice.sv
// axil_rdata_fifo_slice
// AXI4-Lite read-data (R) channel buffer. A DEPTH-entry FIFO holds
// {RRESP, RDATA} beats between a slave-side producer and a master-side
// consumer. Both sides use full VALID/READY handshaking. The block also
// reports occupancy and keeps a saturating count of error responses.
//
// Ports:
//   ACLK        clock; all logic updates on the rising edge
//   ARESETn     synchronous reset, active-high (1 = reset)
//   s_RVALID    upstream beat valid
//   s_RREADY    buffer can accept a beat (full decodes from registered count)
//   s_RDATA     upstream read data
//   s_RRESP     upstream read response
//   m_RVALID    downstream beat valid (not empty)
//   m_RREADY    downstream consumer ready
//   m_RDATA     head-of-FIFO data, forced to 0 while m_RVALID=0
//   m_RRESP     head-of-FIFO response, forced to 0 while m_RVALID=0
//   o_COUNT     current occupancy, 0..DEPTH
//   o_ERRCNT    saturating count of delivered beats with RRESP[1]=1
//   clr_ERRCNT  synchronous clear of o_ERRCNT
module axil_rdata_fifo_slice #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ERR_W  = 8
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     s_RVALID,
    output logic                     s_RREADY,
    input  logic [DATA_W-1:0]        s_RDATA,
    input  logic [1:0]               s_RRESP,
    output logic                     m_RVALID,
    input  logic                     m_RREADY,
    output logic [DATA_W-1:0]        m_RDATA,
    output logic [1:0]               m_RRESP,
    output logic [$clog2(DEPTH):0]   o_COUNT,
    output logic [ERR_W-1:0]         o_ERRCNT,
    input  logic                     clr_ERRCNT
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = DATA_W + 2;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [ERR_W-1:0] errcnt;

    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    // Handshake flags decode only the registered count, so s_RREADY has no
    // combinational path from m_RREADY.
    always_comb begin
        s_RREADY = (count != FULL_COUNT);
        m_RVALID = (count != '0);
        push     = s_RVALID && s_RREADY;
        pop      = m_RVALID && m_RREADY;
        head     = mem[rd_ptr];
        m_RDATA  = m_RVALID ? head[DATA_W-1:0] : '0;
        m_RRESP  = m_RVALID ? head[EW-1:DATA_W] : '0;
    end

    assign o_COUNT  = count;
    assign o_ERRCNT = errcnt;

    // Storage is never cleared; the pointers and count alone decide which
    // entries are live.
    always_ff @(posedge ACLK) begin
        if (!ARESETn && push) begin
            mem[wr_ptr] <= {s_RRESP, s_RDATA};
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // RRESP[1] set means SLVERR or DECERR; the counter sticks at all-ones.
    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            errcnt <= '0;
        end else if (clr_ERRCNT) begin
            errcnt <= '0;
        end else if (pop && head[EW-1] && (errcnt != '1)) begin
            errcnt <= errcnt + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_axil_rdata_fifo_slice.sv
// Testbench for axil_rdata_fifo_slice: directed scenarios plus randomized
// traffic, all checked every cycle against a queue-based reference model.
module tb_axil_rdata_fifo_slice;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ERR_W   = 2;
    localparam int unsigned ERR_MAX = (1 << ERR_W) - 1;

    logic                   ACLK = 1'b0;
    logic                   ARESETn;
    logic                   s_RVALID;
    logic                   s_RREADY;
    logic [DATA_W-1:0]      s_RDATA;
    logic [1:0]             s_RRESP;
    logic                   m_RVALID;
    logic                   m_RREADY;
    logic [DATA_W-1:0]      m_RDATA;
    logic [1:0]             m_RRESP;
    logic [$clog2(DEPTH):0] o_COUNT;
    logic [ERR_W-1:0]       o_ERRCNT;
    logic                   clr_ERRCNT;

    axil_rdata_fifo_slice #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ERR_W  (ERR_W)
    ) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .s_RVALID   (s_RVALID),
        .s_RREADY   (s_RREADY),
        .s_RDATA    (s_RDATA),
        .s_RRESP    (s_RRESP),
        .m_RVALID   (m_RVALID),
        .m_RREADY   (m_RREADY),
        .m_RDATA    (m_RDATA),
        .m_RRESP    (m_RRESP),
        .o_COUNT    (o_COUNT),
        .o_ERRCNT   (o_ERRCNT),
        .clr_ERRCNT (clr_ERRCNT)
    );

    always #5 ACLK = ~ACLK;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: queue of {resp, data} beats plus the expected counter.
    logic [DATA_W+1:0] model_q [$];
    int unsigned       exp_err = 0;
    logic              last_push;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_err++;
            $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic check_outputs();
        logic [DATA_W+1:0] hd;
        hd = '0;
        if (model_q.size() != 0) hd = model_q[0];
        check("count",    64'(o_COUNT),  64'(model_q.size()));
        check("s_rready", 64'(s_RREADY), 64'(model_q.size() != DEPTH));
        check("m_rvalid", 64'(m_RVALID), 64'(model_q.size() != 0));
        check("m_rdata",  64'(m_RDATA),  64'(hd[DATA_W-1:0]));
        check("m_rresp",  64'(m_RRESP),  64'(hd[DATA_W+1:DATA_W]));
        check("errcnt",   64'(o_ERRCNT), 64'(exp_err));
    endtask

    // Drive one cycle of inputs, advance the model by the rules of a FIFO,
    // then compare after the edge.
    task automatic cycle(input logic sv, input logic [DATA_W-1:0] sd,
                         input logic [1:0] sr, input logic mr,
                         input logic clr, input logic rst);
        logic do_push;
        logic do_pop;
        logic [DATA_W+1:0] e;
        s_RVALID   = sv;
        s_RDATA    = sd;
        s_RRESP    = sr;
        m_RREADY   = mr;
        clr_ERRCNT = clr;
        ARESETn    = rst;
        do_push = sv && (model_q.size() < DEPTH);
        do_pop  = mr && (model_q.size() != 0);
        e = '0;
        last_push = do_push && !rst;
        if (rst) begin
            model_q.delete();
            exp_err = 0;
        end else begin
            if (do_pop) e = model_q.pop_front();
            if (clr) exp_err = 0;
            else if (do_pop && e[DATA_W+1] && exp_err < ERR_MAX) exp_err++;
            if (do_push) model_q.push_back({sr, sd});
        end
        @(posedge ACLK);
        #1;
        check_outputs();
    endtask

    initial begin
        logic accepted;
        ARESETn = 1'b1; s_RVALID = 1'b0; s_RDATA = '0; s_RRESP = '0;
        m_RREADY = 1'b0; clr_ERRCNT = 1'b0;

        // Reset then idle.
        cycle(0, '0, 2'b00, 0, 0, 1);
        cycle(0, '0, 2'b00, 0, 0, 1);
        cycle(0, '0, 2'b00, 0, 0, 0);
        check("idle_rdata", 64'(m_RDATA), 64'h0);

        // Single beat, visible one cycle after the push edge.
        cycle(1, 32'hDEADBEEF, 2'b00, 1, 0, 0);
        check("single_beat", 64'(m_RDATA), 64'hDEADBEEF);
        cycle(0, '0, 2'b00, 1, 0, 0);
        check("single_empty", 64'(o_COUNT), 64'd0);

        // Fill past full with the consumer stalled, then drain.
        for (int i = 1; i <= 5; i++) cycle(1, DATA_W'(i), 2'b00, 0, 0, 0);
        check("full_count", 64'(o_COUNT), 64'd4);
        accepted = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cycle(!accepted, 32'd5, 2'b00, 1, 0, 0);
            if (last_push) accepted = 1'b1;
        end

        // Streaming with both sides always ready.
        for (int i = 0; i < 64; i++) cycle(1, 32'h1000 + DATA_W'(i), 2'b00, 1, 0, 0);
        cycle(0, '0, 2'b00, 1, 0, 0);

        // Error counter saturation, clear-wins priority, OKAY leaves it alone.
        cycle(0, '0, 2'b00, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, 32'hE000 + DATA_W'(i), 2'b10, 1, 0, 0);
        cycle(1, 32'hDEC0, 2'b11, 1, 0, 0);
        check("err_saturated", 64'(o_ERRCNT), 64'd3);
        cycle(0, '0, 2'b00, 1, 1, 0);
        check("err_clear_wins", 64'(o_ERRCNT), 64'd0);
        cycle(1, 32'h0C0C, 2'b00, 1, 0, 0);
        cycle(0, '0, 2'b00, 1, 0, 0);

        // Reset mid-operation discards buffered beats.
        for (int i = 0; i < 3; i++) cycle(1, 32'hA0 + DATA_W'(i), 2'b00, 0, 0, 0);
        cycle(0, '0, 2'b00, 1, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, '0, 2'b00, 1, 0, 0);

        // Randomized traffic with occasional clears and resets.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0,
                  $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
